// File: rtl/ac_motor_carrier_gen.sv
// rtl/ac_motor_carrier_gen.sv - multi-channel triangle/sawtooth PWM carrier with period-boundary latching
// Amplitude, mode and direction only change at latch events so downstream comparators never see a mid-period step.
module ac_motor_carrier_gen #(
    parameter int CHANNELS        = 3,
    parameter int BITS            = 12,
    parameter int LEVEL_BITS      = 5,
    parameter int START_AMPLITUDE = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    enable,
    input  logic                                    mode,
    input  logic [LEVEL_BITS-1:0]                   amplitude,
    input  logic                                    cw_in,
    input  logic                                    ccw_in,
    output logic                                    cw_out,
    output logic                                    ccw_out,
    output logic [CHANNELS*(BITS+LEVEL_BITS)-1:0]   carrier,
    output logic                                    peak,
    output logic                                    period_start,
    output logic [LEVEL_BITS-1:0]                   amp_active
);

    localparam int W  = BITS + LEVEL_BITS;
    localparam int PW = W + 1;

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                 state, state_n;
    logic signed [PW-1:0]   pos, pos_n;
    logic [LEVEL_BITS-1:0]  amp, latch_amp;
    logic                   mode_l;
    logic                   latch;
    logic                   peak_p, peak_n;
    logic                   start_p, start_n;
    logic signed [PW-1:0]   cur_max, cur_min, step, new_min, up_sum, dn_diff;
    logic [W-1:0]           neg_w;
    logic [CHANNELS*W-1:0]  carrier_n;

    assign amp_active = amp;
    assign latch_amp  = (amplitude == '0) ? LEVEL_BITS'(1) : amplitude;
    assign step       = $signed({{(PW-LEVEL_BITS){1'b0}}, amp});
    assign cur_max    = step <<< (BITS-1);
    assign cur_min    = -cur_max;
    assign new_min    = -($signed({{(PW-LEVEL_BITS){1'b0}}, latch_amp}) <<< (BITS-1));
    assign up_sum     = pos + step;
    assign dn_diff    = pos - step;

    // Disable wins over peak/valley handling and suppresses strobes.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        latch   = 1'b0;
        peak_n  = 1'b0;
        start_n = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            pos_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    latch   = 1'b1;
                    start_n = 1'b1;
                    state_n = UP;
                    pos_n   = '0;
                end
                UP: begin
                    if (up_sum < cur_max) begin
                        pos_n = up_sum;
                    end else begin
                        peak_n = 1'b1;
                        if (!mode_l) begin
                            pos_n   = cur_max;
                            state_n = DOWN;
                        end else begin
                            // Sawtooth wrap lands on the valley of the newly latched amplitude.
                            latch   = 1'b1;
                            pos_n   = new_min;
                            start_n = 1'b1;
                            state_n = UP;
                        end
                    end
                end
                DOWN: begin
                    if (dn_diff > cur_min) begin
                        pos_n = dn_diff;
                    end else begin
                        pos_n   = cur_min;
                        latch   = 1'b1;
                        start_n = 1'b1;
                        state_n = UP;
                    end
                end
                default: begin
                    state_n = IDLE;
                    pos_n   = '0;
                end
            endcase
        end
    end

    assign neg_w = -pos[W-1:0];

    always_comb begin
        carrier_n = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            carrier_n[k*W +: W] = (k % 2 == 1) ? neg_w : pos[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pos     <= '0;
            amp     <= LEVEL_BITS'(START_AMPLITUDE);
            mode_l  <= 1'b0;
            cw_out  <= 1'b0;
            ccw_out <= 1'b1;
            peak_p  <= 1'b0;
            start_p <= 1'b0;
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            peak_p  <= peak_n;
            start_p <= start_n;
            if (latch) begin
                amp     <= latch_amp;
                mode_l  <= mode;
                cw_out  <= cw_in;
                ccw_out <= ccw_in;
            end
        end
    end

    // Strobes travel with the pos sample they describe through the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier      <= '0;
            peak         <= 1'b0;
            period_start <= 1'b0;
        end else begin
            carrier      <= carrier_n;
            peak         <= peak_p;
            period_start <= start_p;
        end
    end

endmodule

// File: tb/tb_ac_motor_carrier_gen.sv
// tb/tb_ac_motor_carrier_gen.sv - scoreboard bench for ac_motor_carrier_gen
module tb_ac_motor_carrier_gen;

    localparam int CH = 3;
    localparam int LB = 5;
    localparam int W  = 12 + LB;
    localparam int S  = 2048;

    logic clk = 1'b0;
    logic rst_n;
    logic enable, mode, cw_in, ccw_in;
    logic [LB-1:0] amp_in;
    logic cw_out, ccw_out, peak, period_start;
    logic [CH*W-1:0] carrier;
    logic [LB-1:0] amp_active;

    ac_motor_carrier_gen #(.CHANNELS(CH), .BITS(12), .LEVEL_BITS(LB), .START_AMPLITUDE(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .amplitude(amp_in),
        .cw_in(cw_in), .ccw_in(ccw_in), .cw_out(cw_out), .ccw_out(ccw_out),
        .carrier(carrier), .peak(peak), .period_start(period_start), .amp_active(amp_active)
    );

    always #5 clk = ~clk;

    typedef struct { int pos; bit pk; bit st; } exp_t;
    exp_t q[$];

    int total = 0, fails = 0;
    int m_state, m_pos, m_amp;
    bit m_mode, m_cw, m_ccw, m_pk, m_st;
    int cyc = 0, n_peak, n_start, n_both, peak_ch0, peak_ch1, start_ch0;
    int peak_cyc[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] ch(input int k);
        logic signed [W-1:0] v;
        v = carrier[k*W +: W];
        return 32'(v);
    endfunction

    task automatic model_latch();
        m_amp  = (amp_in == 0) ? 1 : int'(amp_in);
        m_mode = mode;
        m_cw   = cw_in;
        m_ccw  = ccw_in;
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_amp = 2; m_mode = 0; m_cw = 0; m_ccw = 1;
        q.delete();
        q.push_back('{0, 1'b0, 1'b0});
    endtask

    task automatic model_step();
        m_pk = 0; m_st = 0;
        if (!enable) begin
            m_state = 0; m_pos = 0;
        end else if (m_state == 0) begin
            model_latch(); m_st = 1; m_state = 1; m_pos = 0;
        end else if (m_state == 1) begin
            if (m_pos + m_amp < m_amp * S) m_pos += m_amp;
            else begin
                m_pk = 1;
                if (!m_mode) begin m_pos = m_amp * S; m_state = 2; end
                else begin model_latch(); m_pos = -m_amp * S; m_st = 1; end
            end
        end else begin
            if (m_pos - m_amp > -m_amp * S) m_pos -= m_amp;
            else begin m_pos = -m_amp * S; model_latch(); m_st = 1; m_state = 1; end
        end
    endtask

    task automatic clear_obs();
        n_peak = 0; n_start = 0; n_both = 0; peak_ch0 = 0; peak_ch1 = 0; start_ch0 = 0;
        peak_cyc.delete();
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        q.push_back('{m_pos, m_pk, m_st});
        @(negedge clk);
        cyc++;
        e = q.pop_front();
        chk("ch0", ch(0), e.pos);
        chk("ch1", ch(1), -e.pos);
        chk("ch2", ch(2), e.pos);
        chk("peak", 32'(peak), 32'(e.pk));
        chk("start", 32'(period_start), 32'(e.st));
        chk("cw", 32'(cw_out), 32'(m_cw));
        chk("ccw", 32'(ccw_out), 32'(m_ccw));
        chk("amp", 32'(amp_active), m_amp);
        if (peak === 1'b1) begin n_peak++; peak_ch0 = ch(0); peak_ch1 = ch(1); peak_cyc.push_back(cyc); end
        if (period_start === 1'b1) begin n_start++; start_ch0 = ch(0); end
        if (peak === 1'b1 && period_start === 1'b1) n_both++;
    endtask

    task automatic run_until_start(input int budget, input string tag);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (period_start === 1'b1) begin found = 1; break; end
        end
        chk(tag, 32'(found), 1);
    endtask

    initial begin
        bit found;
        rst_n = 0; enable = 0; mode = 0; amp_in = 2; cw_in = 0; ccw_in = 1;
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1;

        // 1: async reset mid-run, release with enable low
        enable = 1;
        repeat (100) tick();
        #2 rst_n = 0;
        #1;
        chk("rst_ch0", ch(0), 0);
        chk("rst_ch1", ch(1), 0);
        chk("rst_cw", 32'(cw_out), 0);
        chk("rst_ccw", 32'(ccw_out), 1);
        chk("rst_amp", 32'(amp_active), 2);
        chk("rst_peak", 32'(peak), 0);
        chk("rst_start", 32'(period_start), 0);
        enable = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1;
        clear_obs();
        repeat (5) tick();
        chk("idle_strobes", n_start + n_peak, 0);
        chk("idle_ch0", ch(0), 0);

        // 2: triangle, amplitude 2
        enable = 1;
        clear_obs();
        repeat (6150) tick();
        chk("t2_npeak", n_peak, 1);
        chk("t2_peak_ch0", peak_ch0, 4096);
        chk("t2_peak_ch1", peak_ch1, -4096);
        chk("t2_nstart", n_start, 2);
        chk("t2_valley_ch0", start_ch0, -4096);

        // 3: amplitude change mid-ramp takes effect at the valley
        repeat (1000) tick();
        amp_in = 5;
        clear_obs();
        tick();
        chk("t3_amp_hold", 32'(amp_active), 2);
        repeat (10999) tick();
        chk("t3_npeak", n_peak, 2);
        chk("t3_peak_ch0", peak_ch0, 10240);
        chk("t3_peak_ch1", peak_ch1, -10240);
        chk("t3_nstart", n_start, 1);
        chk("t3_valley_ch0", start_ch0, -4096);
        chk("t3_amp_new", 32'(amp_active), 5);

        // 4: sawtooth, amplitude 1
        enable = 0;
        repeat (2) tick();
        mode = 1; amp_in = 1; enable = 1;
        clear_obs();
        repeat (6150) tick();
        chk("t4_npeak", n_peak, 2);
        chk("t4_both", n_both, 2);
        chk("t4_wrap_ch0", peak_ch0, -2048);
        chk("t4_nstart", n_start, 3);
        chk("t4_period", peak_cyc[1] - peak_cyc[0], 4096);

        // 5: direction and amplitude latch at period boundaries
        cw_in = 1; ccw_in = 0; amp_in = 3;
        repeat (10) tick();
        chk("t5_cw_hold", 32'(cw_out), 0);
        chk("t5_ccw_hold", 32'(ccw_out), 1);
        run_until_start(5000, "t5_wrap1_timeout");
        chk("t5_cw_new", 32'(cw_out), 1);
        chk("t5_ccw_new", 32'(ccw_out), 0);
        chk("t5_amp3", 32'(amp_active), 3);
        amp_in = 0;
        run_until_start(5000, "t5_wrap2_timeout");
        chk("t5_amp_clamp", 32'(amp_active), 1);

        // 6: disable exactly at a valley, then re-enable
        mode = 0; amp_in = 8;
        run_until_start(5000, "t6_wrap_timeout");
        chk("t6_amp8", 32'(amp_active), 8);
        found = 0;
        for (int i = 0; i < 10000; i++) begin
            if (m_state == 2 && m_pos - m_amp <= -m_amp * S) begin found = 1; break; end
            tick();
        end
        chk("t6_valley_timeout", 32'(found), 1);
        enable = 0;
        clear_obs();
        tick();
        tick();
        chk("t6_no_start", n_start, 0);
        chk("t6_idle_ch0", ch(0), 0);
        enable = 1;
        tick();
        tick();
        chk("t6_restart_start", 32'(period_start), 1);
        chk("t6_restart_ch0", ch(0), 0);
        tick();
        chk("t6_ramp1", ch(0), 8);
        tick();
        chk("t6_ramp2", ch(0), 16);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/ac_motor_carrier_gen.md
Name: ac_motor_carrier_gen

Overview:
Parametrised multi-channel carrier generator for the AC motor PWM path. It produces a symmetric triangle or sawtooth carrier whose amplitude, mode and rotation direction are re-latched only at period boundaries, so the comparators downstream never see a mid-period step. It drives CHANNELS carrier outputs, with odd channels inverted for interleaved bridge legs. It also provides peak and period strobes for sampling and control-loop timing.

Parameters:
CHANNELS, 3, number of carrier outputs; channel k is inverted when k is odd.
BITS, 12, base resolution; scale factor is 2^(BITS-1).
LEVEL_BITS, 5, width of the AMPLITUDE input.
START_AMPLITUDE, 2, amplitude loaded at reset; must be in 1..2^LEVEL_BITS-1.

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  run carrier; low forces IDLE
MODE  in  1  0 = triangle, 1 = sawtooth (ramp up, then wrap)
AMPLITUDE  in  LEVEL_BITS  requested amplitude level, also the step size
CW_IN  in  1  clockwise request
CCW_IN  in  1  counter-clockwise request
CW_OUT  out  1  latched clockwise direction
CCW_OUT  out  1  latched counter-clockwise direction
CARRIER  out  CHANNELS*(BITS+LEVEL_BITS)  flat vector of signed carriers; channel k occupies bits [k*W +: W], where W = BITS+LEVEL_BITS
PEAK  out  1  one-cycle strobe when the carrier reaches max
PERIOD_START  out  1  one-cycle strobe at each period boundary (valley or wrap)
AMP_ACTIVE  out  LEVEL_BITS  amplitude currently in use

Behaviour:
- Reset (RST_N low, asynchronous):
  - pos = 0, state = IDLE, amp = START_AMPLITUDE, mode_l = 0.
  - CW_OUT = 0, CCW_OUT = 1.
  - CARRIER = 0, PEAK = 0, PERIOD_START = 0.
  - Reset release mid-period restarts cleanly from IDLE.
- Internal values:
  - pos is signed, W+1 bits wide; the extra bit absorbs pos+step overflow.
  - max = amp * 2^(BITS-1); min = -max; step = amp.
  - Latch rule: amp = AMPLITUDE, except AMPLITUDE = 0 is clamped to 1. The same event latches mode_l = MODE, CW_OUT = CW_IN and CCW_OUT = CCW_IN.
- States: IDLE, UP, DOWN.
  - IDLE, ENABLE = 0: pos = 0, no strobes.
  - IDLE, ENABLE = 1:
    - Performs a latch event.
    - Pulses PERIOD_START.
    - Next state UP with pos = 0.
  - UP, pos + step < max: pos += step.
  - UP, pos + step >= max:
    - Pulses PEAK.
    - Triangle (mode_l = 0): pos = max (clamp), next state DOWN.
    - Sawtooth (mode_l = 1): performs a latch event, then pos = min computed with the new amp, and pulses PERIOD_START in the same cycle as PEAK. State stays UP unless the new mode is triangle, in which case pos = min and state is UP.
  - DOWN, pos - step > min: pos -= step.
  - DOWN, pos - step <= min:
    - pos = min.
    - Performs a latch event; max, min and step use the new amp from the next cycle on.
    - Pulses PERIOD_START, next state UP.
  - ENABLE low in UP or DOWN: IDLE on the next edge with pos = 0. This takes priority over peak and valley handling; no strobe in that cycle.
- Timing:
  - AMPLITUDE, MODE, CW_IN and CCW_IN changes mid-period have no effect until the next latch event.
  - AMP_ACTIVE reflects amp combinationally from its register.
- Outputs are registered and lag pos by 1 cycle:
  - Channel k = pos if k is even, -pos if k is odd, truncated to W bits (always representable, since |max| <= (2^LEVEL_BITS-1) * 2^(BITS-1)).
  - PEAK and PERIOD_START are registered alongside CARRIER, so each strobe aligns with the carrier sample it describes.

Test Plan:
1. RST_N low mid-run, then high with ENABLE = 0 → CARRIER = 0, CW_OUT = 0, CCW_OUT = 1, AMP_ACTIVE = 2; strobes stay low.
2. Defaults, ENABLE = 1, MODE = 0, AMPLITUDE = 2 → channel 0 ramps 0, 2, 4, … and reaches 4096 after 2048 UP cycles with PEAK high for exactly that sample. It then falls to -4096 and PERIOD_START pulses there. Channel 1 mirrors as -4096 / +4096.
3. AMPLITUDE changed from 2 to 5 mid-ramp → the slope stays 2 until the valley. The next period rises by 5 per cycle to 10240, and AMP_ACTIVE becomes 5 only at the valley.
4. MODE = 1, AMPLITUDE = 1 → ramp from 0 to 2048, then wrap to -2048 with PEAK and PERIOD_START in the same cycle; then a full ramp -2048 → 2048 in 4096 cycles.
5. CW_IN = 1, CCW_IN = 0 applied mid-period → CW_OUT and CCW_OUT change only on the PERIOD_START cycle. AMPLITUDE = 0 at a latch → AMP_ACTIVE = 1.
6. ENABLE dropped in DOWN at the same cycle the valley is reached → IDLE, CARRIER = 0 one cycle later, no PERIOD_START. Re-enable → PERIOD_START pulses and the ramp restarts from 0.
